// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the round datapath stages.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam int unsigned NUM_COLS = 4;
  localparam byte_t       AES_POLY = 8'h1B;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Start/done handshake and state bus shared by the AES round stages.
interface mix_columns_seq_if;

  logic         enableMixColumns;
  logic [0:127] state;
  logic [0:127] stateOut;
  logic         mixColumnsDone;
  logic         busy;

  modport master (
    output enableMixColumns,
    output state,
    input  stateOut,
    input  mixColumnsDone,
    input  busy
  );

  modport slave (
    input  enableMixColumns,
    input  state,
    output stateOut,
    output mixColumnsDone,
    output busy
  );

endinterface

// File: rtl/mix_single_column.sv
// Combinational forward MixColumns of one 32-bit column; row 0 sits in the top byte.
module mix_single_column
  import aes_pkg::*;
(
  input  word_t col_in,
  output word_t col_out_c
);

  byte_t a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out_c = {
    xtime(a0)   ^ gf_mul3(a1) ^ a2          ^ a3,
    a0          ^ xtime(a1)   ^ gf_mul3(a2) ^ a3,
    a0          ^ a1          ^ xtime(a2)   ^ gf_mul3(a3),
    gf_mul3(a0) ^ a1          ^ a2          ^ xtime(a3)
  };

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial forward AES MixColumns stage with start-edge/done handshake.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  mix_columns_seq_if.slave bus
);

  localparam int unsigned NUM_STEPS = NUM_COLS / COLS_PER_CYCLE;
  localparam int unsigned CNT_W     = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_prev_q, en_prev_d;
  logic [0:127]     st_in_q, st_in_d;
  logic [0:127]     state_out_q, state_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             start_c;

  word_t lane_in  [COLS_PER_CYCLE];
  word_t lane_out [COLS_PER_CYCLE];

  // Select the columns handled this step from the captured state.
  always_comb begin
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      logic [1:0] col;
      col        = 2'(32'(cnt_q) * COLS_PER_CYCLE + i);
      lane_in[i] = st_in_q[{col, 5'b0} +: 32];
    end
  end

  for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_lane
    mix_single_column u_col (
      .col_in   (lane_in[g]),
      .col_out_c(lane_out[g])
    );
  end

  assign start_c = bus.enableMixColumns & ~en_prev_q;

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    en_prev_d   = bus.enableMixColumns;
    st_in_d     = st_in_q;
    state_out_d = state_out_q;
    done_d      = done_q;
    busy_d      = busy_q;

    case (fsm_q)
      ST_IDLE, ST_DONE: begin
        if (start_c) begin
          fsm_d   = ST_RUN;
          st_in_d = bus.state;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Starts seen here are dropped, not queued.
        for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
          logic [1:0] col;
          col = 2'(32'(cnt_q) * COLS_PER_CYCLE + i);
          state_out_d[{col, 5'b0} +: 32] = lane_out[i];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          fsm_d  = ST_DONE;
          cnt_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= '0;
      en_prev_q   <= 1'b0;
      st_in_q     <= '0;
      state_out_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      en_prev_q   <= en_prev_d;
      st_in_q     <= st_in_d;
      state_out_q <= state_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.stateOut       = state_out_q;
  assign bus.mixColumnsDone = done_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Drives three instances (1, 2 and 4 columns per clock) in lockstep against a GF(2^8) matrix model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [0:127] st;

  always #5 clk = ~clk;

  mix_columns_seq_if if1 ();
  mix_columns_seq_if if2 ();
  mix_columns_seq_if if4 ();

  assign if1.enableMixColumns = en;
  assign if2.enableMixColumns = en;
  assign if4.enableMixColumns = en;
  assign if1.state = st;
  assign if2.state = st;
  assign if4.state = st;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst(rst), .bus(if4.slave));

  logic [0:127] so [3];
  logic         dn [3];
  logic         bz [3];

  assign so[0] = if1.stateOut;
  assign so[1] = if2.stateOut;
  assign so[2] = if4.stateOut;
  assign dn[0] = if1.mixColumnsDone;
  assign dn[1] = if2.mixColumnsDone;
  assign dn[2] = if4.mixColumnsDone;
  assign bz[0] = if1.busy;
  assign bz[1] = if2.busy;
  assign bz[2] = if4.busy;

  int unsigned  cpc [3] = '{1, 2, 4};
  int unsigned  lat [3] = '{4, 2, 1};
  logic [0:127] exp_out [3];
  int           n_checks = 0;
  int           n_fail   = 0;

  // Carry-less product reduced by the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] mcol(input logic [31:0] w, input bit inv);
    logic [7:0]  a [4];
    logic [7:0]  coef [4];
    logic [7:0]  r;
    logic [31:0] o;
    if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int j = 0; j < 4; j++) a[j] = w[31-8*j -: 8];
    o = '0;
    for (int row = 0; row < 4; row++) begin
      r = '0;
      for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - row + 4) % 4], a[j]);
      o[31-8*row -: 8] = r;
    end
    return o;
  endfunction

  function automatic logic [0:127] mstate(input logic [0:127] s, input bit inv);
    logic [0:127] o;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = mcol(s[32*c +: 32], inv);
    return o;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on all instances with per-cycle done/busy/partial-column checks.
  task automatic run_op(input logic [0:127] s, input bit scramble, input bit drop_en);
    logic [0:127] fin;
    logic [0:127] expv;
    int unsigned  ncol;
    fin = mstate(s, 1'b0);
    st  = s;
    en  = 1'b1;
    tick();
    if (scramble) st = rand128();
    if (drop_en) en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (bz[d] !== 1'b1 || dn[d] !== 1'b0 || so[d] !== exp_out[d]) begin
        n_fail++;
        $display("FAIL start_edge c=%0d busy=%b done=%b out=%h, required busy=1 done=0 out=%h",
                 cpc[d], bz[d], dn[d], so[d], exp_out[d]);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        ncol = k * cpc[d];
        if (ncol > 4) ncol = 4;
        for (int c = 0; c < 4; c++)
          expv[32*c +: 32] = (c < int'(ncol)) ? fin[32*c +: 32] : exp_out[d][32*c +: 32];
        n_checks++;
        if (dn[d] !== (k >= int'(lat[d])) || bz[d] !== (k < int'(lat[d])) || so[d] !== expv) begin
          n_fail++;
          $display("FAIL run_cycle c=%0d k=%0d busy=%b done=%b out=%h, required busy=%b done=%b out=%h",
                   cpc[d], k, bz[d], dn[d], so[d], k < int'(lat[d]), k >= int'(lat[d]), expv);
        end
      end
    end
    for (int d = 0; d < 3; d++) exp_out[d] = fin;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    st  = '0;
    tick();
    tick();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) exp_out[d] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (so[d] !== 128'h0 || dn[d] !== 1'b0 || bz[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state c=%0d out=%h done=%b busy=%b, required all zero",
                 cpc[d], so[d], dn[d], bz[d]);
      end
    end
  endtask

  task automatic test_known_vector();
    logic [0:127] req;
    req = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    run_op(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (so[d] !== req) begin
        n_fail++;
        $display("FAIL known_vector c=%0d out=%h, required %h", cpc[d], so[d], req);
      end
    end
    tick();
  endtask

  task automatic test_columns();
    logic [31:0]  vin  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                               32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    logic [31:0]  vout [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                               32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
    logic [0:127] s;
    int           idx;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 4; c++) s[32*c +: 32] = vin[(4*pass + c) % 6];
      run_op(s, 1'b0, 1'b1);
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < 4; c++) begin
          idx = (4*pass + c) % 6;
          n_checks++;
          if (so[d][32*c +: 32] !== vout[idx]) begin
            n_fail++;
            $display("FAIL column_vector c=%0d col=%0d in=%h out=%h, required %h",
                     cpc[d], c, vin[idx], so[d][32*c +: 32], vout[idx]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_level_hold();
    run_op(rand128(), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (dn[d] !== 1'b1 || bz[d] !== 1'b0 || so[d] !== exp_out[d]) begin
          n_fail++;
          $display("FAIL level_hold c=%0d done=%b busy=%b out=%h, required done=1 busy=0 out=%h",
                   cpc[d], dn[d], bz[d], so[d], exp_out[d]);
        end
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_pulse_while_busy();
    logic [0:127] s;
    logic [0:127] fin;
    s   = rand128();
    fin = mstate(s, 1'b0);
    st  = s;
    en  = 1'b1;
    tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    n_checks++;
    if (dn[0] !== 1'b0 || bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_t3 c=1 done=%b busy=%b, required done=0 busy=1", dn[0], bz[0]);
    end
    tick();
    n_checks++;
    if (dn[0] !== 1'b1 || bz[0] !== 1'b0 || so[0] !== fin) begin
      n_fail++;
      $display("FAIL pulse_t4 c=1 done=%b busy=%b out=%h, required done=1 busy=0 out=%h",
               dn[0], bz[0], so[0], fin);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (dn[0] !== 1'b1 || bz[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_no_rerun c=1 done=%b busy=%b, required done=1 busy=0", dn[0], bz[0]);
      end
    end
    for (int d = 0; d < 3; d++) begin
      exp_out[d] = fin;
      n_checks++;
      if (so[d] !== fin || dn[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_settle c=%0d out=%h done=%b, required out=%h done=1",
                 cpc[d], so[d], dn[d], fin);
      end
    end
    run_op(rand128(), 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_op();
    st = rand128();
    en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (so[d] !== 128'h0 || dn[d] !== 1'b0 || bz[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_op c=%0d out=%h done=%b busy=%b, required all zero",
                 cpc[d], so[d], dn[d], bz[d]);
      end
      exp_out[d] = '0;
    end
    rst = 1'b1;
    en  = 1'b0;
    tick();
    run_op(rand128(), 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_round_trip();
    logic [0:127] s;
    logic [0:127] back;
    for (int n = 0; n < 50; n++) begin
      s = rand128();
      run_op(s, 1'b0, 1'b1);
      for (int d = 0; d < 3; d++) begin
        back = mstate(so[d], 1'b1);
        n_checks++;
        if (back !== s) begin
          n_fail++;
          $display("FAIL round_trip c=%0d n=%0d inverse=%h, required %h", cpc[d], n, back, s);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_columns();
    test_level_hold();
    test_pulse_while_busy();
    test_reset_mid_op();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Forward AES MixColumns for the encryption datapath. It is the counterpart of the decrypt-side inverse MixColumns stage.
- Clocked and column-serial: processes COLS_PER_CYCLE columns per clock, using xtime arithmetic rather than lookup tables.
- Uses the same start/done handshake as the other round stages, so the round controller drives both directions identically.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
enableMixColumns  input  1  start request; a 0->1 transition starts an operation.
state  input  128  [0:127]; byte k = state[8k:8k+7]; column c = bytes 4c..4c+3; byte 4c+r is row r.
stateOut  output  128  [0:127], same byte layout; the MixColumns result.
mixColumnsDone  output  1  high when stateOut holds a complete result.
busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (rst==0 at an edge): stateOut=0, mixColumnsDone=0, busy=0, FSM=IDLE, column counter=0, enable edge-detect register=0. Reset wins over every other event, including mid-operation; any partial result is discarded.
- Edge detect: enPrev registers enableMixColumns every cycle. start = enableMixColumns & ~enPrev.
- A level held high does not restart the block. A 0->1 transition while busy is ignored and not queued.
- FSM has three states:
  - IDLE --start--> RUN
  - RUN --last column--> DONE
  - DONE --start--> RUN
- Start edge (edge T): capture state into the internal register stIn; busy=1; mixColumnsDone=0; counter=0. stateOut keeps its old value until overwritten column by column.
- RUN: on each edge T+1..T+N, where N=4/COLS_PER_CYCLE, columns counter*C..counter*C+C-1 are computed from stIn and written into stateOut; counter increments.
- At edge T+N: busy=0, mixColumnsDone=1, FSM=DONE.
- Latency: N clocks from the accepting edge to mixColumnsDone visible (4, 2 or 1).
- Changing state after edge T has no effect on the result.
- DONE: stateOut and mixColumnsDone hold until the next start edge, or until reset.
- Column math, GF(2^8) with modulus 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0):
  - b0' = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1' = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2' = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3' = 3a0 ^ a1 ^ a2 ^ 2a3
  - 3x = xtime(x) ^ x.
- All arithmetic is 8-bit with no carry out; every result is exactly 8 bits.
- Counter width is 2 bits. It wraps to 0 on entry to DONE and is ignored in IDLE and DONE.

Decomposition:
- Shared package aes_pkg holds:
  - the byte typedef;
  - the 32-bit word typedef;
  - the NUM_COLS=4 constant;
  - the AES_POLY=8'h1B constant;
  - the xtime and gf_mul3 functions.
  The inverse stage is also to be migrated onto this package.
- Sub-module mix_single_column is purely combinational (word in, word out). It is instantiated COLS_PER_CYCLE times and reused by the key-schedule-independent round datapath.
- The top level contains only the FSM, the counter, edge detect, the capture register and the output write mux.

Test Plan:
1. C=1; state = d4bf5d30_e0b452ae_b84111f1_1e2798e5, enable 0->1. Required: stateOut = 046681e5_e0cb199a_48f8d37a_2806264c; mixColumnsDone rises exactly 4 cycles after the accepting edge; busy high for exactly those 4 cycles.
2. Column vectors, checked for C=1, 2 and 4. Required per column:
   - db135345 -> 8e4da1bc
   - f20a225c -> 9fdc589d
   - 01010101 -> 01010101
   - c6c6c6c6 -> c6c6c6c6
   - d4d4d4d5 -> d5d5d7d6
   - 2d26314c -> 4d7ebdf8
   Done latency must equal 4, 2 and 1 cycles respectively.
3. Hold enable high for 10 cycles; change state at T+1. Required: exactly one operation, and the result matches the value captured at T.
4. Pulse enable again at T+2 (C=1). Required: the pulse is ignored, done still arrives at T+4, and there is no second run. A later fresh edge in DONE clears mixColumnsDone on the next edge and reruns.
5. Drive rst=0 at T+2 mid-operation. Required: on the next edge stateOut=0, mixColumnsDone=0, busy=0. After release, the first start edge behaves normally.
6. Round trip: feed 50 random states through mix_columns_seq, then through the inverse stage. Required: every output equals the original state.
